// File: rtl/redmule_tile_pkg.sv
// Tile-level shared types: OBI channel field types, SRAM sizing and the
// response entry carried through the OBI SRAM responder.
package redmule_tile_pkg;

  localparam int unsigned OBI_ADDR_W    = 32;
  localparam int unsigned OBI_DATA_W    = 32;
  localparam int unsigned AID_WIDTH     = 4;
  localparam int unsigned RID_WIDTH     = AID_WIDTH;
  localparam int unsigned L1_SRAM_WORDS = 1024;

  typedef logic [OBI_ADDR_W-1:0]   obi_addr_t;
  typedef logic [OBI_DATA_W-1:0]   obi_data_t;
  typedef logic [OBI_DATA_W/8-1:0] obi_be_t;
  typedef logic [AID_WIDTH-1:0]    obi_aid_t;
  typedef logic [RID_WIDTH-1:0]    obi_rid_t;
  typedef logic [5:0]              obi_atop_t;

  // One R-channel response as queued between acceptance and the handshake.
  typedef struct packed {
    obi_rid_t  rid;
    logic      err;
    obi_data_t rdata;
  } rsp_entry_t;

  // Any non-zero atomic opcode is unsupported by a plain SRAM.
  function automatic logic is_atomic(input obi_atop_t atop);
    return |atop;
  endfunction

endpackage

// File: rtl/obi_rsp_fifo.sv
// Fall-through FIFO: when empty, a pushed entry is visible on data_o in the
// same cycle, and a simultaneous pop consumes it without it being stored.
module obi_rsp_fifo
  import redmule_tile_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = rsp_entry_t
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   push_i,
  input  entry_t data_i,
  input  logic   pop_i,
  output entry_t data_o,
  output logic   valid_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  entry_t           mem_q [DEPTH];
  logic             store;
  logic             take;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign valid_o = ~empty_o | push_i;
  assign data_o  = empty_o ? data_i : mem_q[rptr_q];

  // A push that is consumed in the same cycle by the bypass never occupies a slot.
  assign store = push_i & ~(empty_o & pop_i);
  assign take  = pop_i & ~empty_o;

  // Next-state pointers and occupancy.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (store) wptr_d = ptr_inc(wptr_q);
    if (take)  rptr_d = ptr_inc(rptr_q);
    if (store && !take)      count_d = count_q + CNT_W'(1);
    else if (!store && take) count_d = count_q - CNT_W'(1);
  end

  // Control state register; reset empties the FIFO.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are only observed while occupancy says so.
  always_ff @(posedge clk_i) begin
    if (store) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/obi_sram_responder.sv
// OBI subordinate in front of a single-port, 1-cycle-latency SRAM. Grants
// while fewer than MAX_OUTSTANDING responses are owed, accesses the SRAM in
// the accept cycle, and returns in-order responses through a fall-through
// FIFO. Out-of-range and atomic requests are answered with err=1 and never
// reach the SRAM.
module obi_sram_responder
  import redmule_tile_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h1000_0000,
  parameter int unsigned N_WORDS         = L1_SRAM_WORDS,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter bit          USE_RREADY      = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  // A channel
  input  logic                       obi_req_i,
  output logic                       obi_gnt_o,
  input  logic [31:0]                obi_addr_i,
  input  logic                       obi_we_i,
  input  logic [3:0]                 obi_be_i,
  input  logic [31:0]                obi_wdata_i,
  input  logic [AID_WIDTH-1:0]       obi_aid_i,
  input  logic [5:0]                 obi_atop_i,
  // R channel
  output logic                       obi_rvalid_o,
  input  logic                       obi_rready_i,
  output logic [31:0]                obi_rdata_o,
  output logic [RID_WIDTH-1:0]       obi_rid_o,
  output logic                       obi_err_o,
  // SRAM macro
  output logic                       sram_req_o,
  output logic                       sram_we_o,
  output logic [$clog2(N_WORDS)-1:0] sram_addr_o,
  output logic [3:0]                 sram_be_o,
  output logic [31:0]                sram_wdata_o,
  input  logic [31:0]                sram_rdata_i
);

  localparam int unsigned AW    = $clog2(N_WORDS);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] SPAN  = 32'(N_WORDS * 4);

  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic             rsp_vld_q, rsp_vld_d;
  obi_rid_t         rsp_rid_q, rsp_rid_d;
  logic             rsp_err_q, rsp_err_d;
  logic             rsp_rd_q,  rsp_rd_d;

  logic             rready_eff;
  logic             accept;
  logic             rsp_fire;
  logic [31:0]      offset;
  logic             hit;
  logic             bad;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_valid;
  logic             fifo_full;
  logic             fifo_empty;
  rsp_entry_t       push_entry;
  rsp_entry_t       head_entry;
  logic             unused_sig;

  assign rready_eff = USE_RREADY ? obi_rready_i : 1'b1;

  // Grant depends only on the registered count, never on req or rready.
  assign obi_gnt_o = (outstanding_q < CNT_W'(MAX_OUTSTANDING));
  assign accept    = obi_req_i & obi_gnt_o;
  assign rsp_fire  = fifo_valid & rready_eff;

  // Address decode; the subtraction wraps so addresses below the base miss.
  always_comb begin
    offset = obi_addr_i - BASE_ADDR;
    hit    = (offset < SPAN);
    bad    = ~hit | is_atomic(obi_atop_i);
  end

  // SRAM port is driven in the accept cycle only for good requests; the low
  // two address bits are dropped and the byte enables used as given.
  always_comb begin
    sram_req_o   = accept & ~bad;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_be_o    = '0;
    sram_wdata_o = '0;
    if (sram_req_o) begin
      sram_we_o    = obi_we_i;
      sram_addr_o  = offset[AW+1:2];
      sram_be_o    = obi_be_i;
      sram_wdata_o = obi_wdata_i;
    end
  end

  // Outstanding count: accept and release in the same cycle cancel out.
  always_comb begin
    outstanding_d = outstanding_q;
    if (accept && !rsp_fire)      outstanding_d = outstanding_q + CNT_W'(1);
    else if (!accept && rsp_fire) outstanding_d = outstanding_q - CNT_W'(1);
  end

  // Stage 1 captures the response attributes of this cycle's accepted request.
  always_comb begin
    rsp_vld_d = accept;
    rsp_rid_d = obi_rid_t'(obi_aid_i);
    rsp_err_d = bad;
    rsp_rd_d  = ~bad & ~obi_we_i;
  end

  // Count and stage 1 registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
      rsp_vld_q     <= 1'b0;
      rsp_rid_q     <= '0;
      rsp_err_q     <= 1'b0;
      rsp_rd_q      <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      rsp_vld_q     <= rsp_vld_d;
      rsp_rid_q     <= rsp_rid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_rd_q      <= rsp_rd_d;
    end
  end

  // SRAM read data arrives one cycle after the access, aligned with stage 1.
  always_comb begin
    push_entry.rid   = rsp_rid_q;
    push_entry.err   = rsp_err_q;
    push_entry.rdata = rsp_rd_q ? sram_rdata_i : '0;
  end

  assign fifo_push = rsp_vld_q;
  assign fifo_pop  = rsp_fire;

  obi_rsp_fifo #(
    .DEPTH   (MAX_OUTSTANDING),
    .entry_t (rsp_entry_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (push_entry),
    .pop_i   (fifo_pop),
    .data_o  (head_entry),
    .valid_o (fifo_valid),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // R channel from the FIFO head; payload is held at zero when idle.
  always_comb begin
    obi_rvalid_o = fifo_valid;
    obi_rdata_o  = '0;
    obi_rid_o    = '0;
    obi_err_o    = 1'b0;
    if (fifo_valid) begin
      obi_rdata_o = head_entry.rdata;
      obi_rid_o   = head_entry.rid;
      obi_err_o   = head_entry.err;
    end
  end

  // Address bits outside the word index and FIFO status flags are not
  // needed by the datapath; the grant rule already bounds occupancy.
  assign unused_sig = ^{offset[31:AW+2], offset[1:0], fifo_full, fifo_empty};

endmodule

// File: tb/tb_obi_sram_responder.sv
module tb_obi_sram_responder;
  import redmule_tile_pkg::*;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int unsigned NW   = 1024;
  localparam int unsigned MO   = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 obi_req, obi_gnt, obi_we;
  logic [31:0]          obi_addr, obi_wdata;
  logic [3:0]           obi_be;
  logic [AID_WIDTH-1:0] obi_aid;
  logic [5:0]           obi_atop;
  logic                 obi_rvalid, obi_rready, obi_err;
  logic [31:0]          obi_rdata;
  logic [RID_WIDTH-1:0] obi_rid;
  logic                 sram_req, sram_we;
  logic [9:0]           sram_addr;
  logic [3:0]           sram_be;
  logic [31:0]          sram_wdata;
  logic [31:0]          sram_rdata;

  obi_sram_responder #(
    .BASE_ADDR       (BASE),
    .N_WORDS         (NW),
    .MAX_OUTSTANDING (MO),
    .USE_RREADY      (1'b1)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .obi_req_i    (obi_req),
    .obi_gnt_o    (obi_gnt),
    .obi_addr_i   (obi_addr),
    .obi_we_i     (obi_we),
    .obi_be_i     (obi_be),
    .obi_wdata_i  (obi_wdata),
    .obi_aid_i    (obi_aid),
    .obi_atop_i   (obi_atop),
    .obi_rvalid_o (obi_rvalid),
    .obi_rready_i (obi_rready),
    .obi_rdata_o  (obi_rdata),
    .obi_rid_o    (obi_rid),
    .obi_err_o    (obi_err),
    .sram_req_o   (sram_req),
    .sram_we_o    (sram_we),
    .sram_addr_o  (sram_addr),
    .sram_be_o    (sram_be),
    .sram_wdata_o (sram_wdata),
    .sram_rdata_i (sram_rdata)
  );

  always #5 clk = ~clk;

  // SRAM model with bench-side preload port and access counters.
  logic [31:0] mem [1024];
  logic        pre_en, mem_clr;
  logic [9:0]  pre_addr;
  logic [31:0] pre_data;
  int          sram_req_cnt = 0;
  int          sram_wr_cnt  = 0;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (sram_req) begin
      sram_req_cnt <= sram_req_cnt + 1;
      if (sram_we) begin
        sram_wr_cnt <= sram_wr_cnt + 1;
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  typedef struct {
    logic [RID_WIDTH-1:0] rid;
    logic                 err;
    logic [31:0]          rdata;
    bit                   lat;
    int                   cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          stalls = 0;
  logic        exp_err_drv;
  logic [31:0] exp_rdata_drv;
  bit          lat_drv;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compares every presented response against the scoreboard head
  // and records the expectation of every request accepted this cycle.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        exp_q.delete();
        continue;
      end
      if (dut.fifo_push) chk("fifo_push_not_full", {31'd0, dut.fifo_full}, 32'd0);
      if (obi_rvalid) begin
        if (exp_q.size() == 0) begin
          chk("stale_rsp_rvalid", 32'd1, 32'd0);
        end else begin
          e = exp_q[0];
          chk("rsp_rid", {28'd0, obi_rid}, {28'd0, e.rid});
          chk("rsp_err", {31'd0, obi_err}, {31'd0, e.err});
          chk("rsp_rdata", obi_rdata, e.rdata);
          if (obi_rready) begin
            if (e.lat) chk("rsp_latency_cycle", cyc, e.cyc);
            void'(exp_q.pop_front());
          end
        end
      end
      if (obi_req && obi_gnt) begin
        e.rid   = obi_aid;
        e.err   = exp_err_drv;
        e.rdata = exp_rdata_drv;
        e.lat   = lat_drv;
        e.cyc   = cyc + 1;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic set_req(input logic [31:0] a, input logic we, input logic [3:0] be,
                         input logic [31:0] wd, input logic [3:0] aid, input logic [5:0] atop,
                         input logic e_err, input logic [31:0] e_rd, input bit lat);
    obi_req = 1'b1; obi_addr = a; obi_we = we; obi_be = be; obi_wdata = wd;
    obi_aid = aid; obi_atop = atop;
    exp_err_drv = e_err; exp_rdata_drv = e_rd; lat_drv = lat;
  endtask

  // Issue one request (called just after a rising edge) and hold it until granted.
  task automatic do_req(input logic [31:0] a, input logic we, input logic [3:0] be,
                        input logic [31:0] wd, input logic [3:0] aid, input logic [5:0] atop,
                        input logic e_err, input logic [31:0] e_rd, input bit lat);
    int n = 0;
    set_req(a, we, be, wd, aid, atop, e_err, e_rd, lat);
    @(negedge clk);
    while (!obi_gnt) begin
      n++; stalls++;
      if (n > 40) begin chk("gnt_wait_timeout", 32'd0, 32'd1); break; end
      @(negedge clk);
    end
    @(posedge clk); #1;
    obi_req = 1'b0; obi_we = 1'b0; obi_atop = '0;
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    pre_addr = a; pre_data = d; pre_en = 1'b1;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0, rq0, n;
    rst = 1'b1; mem_clr = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    obi_req = 1'b0; obi_addr = '0; obi_we = 1'b0; obi_be = '0; obi_wdata = '0;
    obi_aid = '0; obi_atop = '0; obi_rready = 1'b1;
    exp_err_drv = 1'b0; exp_rdata_drv = '0; lat_drv = 1'b0;
    fork monitor(); join_none

    // Reset values
    repeat (3) @(negedge clk);
    chk("reset_gnt", {31'd0, obi_gnt}, 32'd1);
    chk("reset_rvalid", {31'd0, obi_rvalid}, 32'd0);
    chk("reset_rdata", obi_rdata, 32'd0);
    chk("reset_err", {31'd0, obi_err}, 32'd0);
    chk("reset_sram_req", {31'd0, sram_req}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; mem_clr = 1'b0;
    @(negedge clk);
    chk("post_reset_gnt", {31'd0, obi_gnt}, 32'd1);
    @(posedge clk); #1;

    // Single read, then unaligned read of the same word
    preload(10'd5, 32'hDEADBEEF);
    do_req(32'h1000_0014, 1'b0, 4'hF, '0, 4'd1, 6'h0, 1'b0, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    chk("single_read_rvalid_t1", {31'd0, obi_rvalid}, 32'd1);
    @(posedge clk); #1;
    do_req(32'h1000_0016, 1'b0, 4'hF, '0, 4'd2, 6'h0, 1'b0, 32'hDEADBEEF, 1'b1);
    idle(2);

    // Byte write then read back
    wr0 = sram_wr_cnt;
    do_req(32'h1000_0000, 1'b1, 4'b0010, 32'h0000AB00, 4'd3, 6'h0, 1'b0, 32'h0, 1'b1);
    do_req(32'h1000_0000, 1'b0, 4'hF, '0, 4'd4, 6'h0, 1'b0, 32'h0000AB00, 1'b1);
    idle(2);
    chk("byte_write_count", sram_wr_cnt - wr0, 32'd1);

    // Last word in range
    preload(10'd1023, 32'hCAFEF00D);
    do_req(32'h1000_0FFC, 1'b0, 4'hF, '0, 4'd5, 6'h0, 1'b0, 32'hCAFEF00D, 1'b1);
    idle(2);

    // Error requests never reach the SRAM
    rq0 = sram_req_cnt;
    do_req(32'h1000_1000, 1'b0, 4'hF, '0, 4'd6, 6'h0, 1'b1, 32'h0, 1'b1);
    do_req(32'h0FFF_FFFC, 1'b0, 4'hF, '0, 4'd7, 6'h0, 1'b1, 32'h0, 1'b1);
    do_req(32'h1000_0008, 1'b1, 4'hF, 32'h12345678, 4'd8, 6'h21, 1'b1, 32'h0, 1'b1);
    idle(2);
    chk("err_no_sram_req", sram_req_cnt - rq0, 32'd0);
    do_req(32'h1000_0008, 1'b0, 4'hF, '0, 4'd8, 6'h0, 1'b0, 32'h0, 1'b1);
    idle(2);

    // Back-pressure: two accepts fill the window, third waits for release
    preload(10'd1, 32'h11111111);
    preload(10'd2, 32'h22222222);
    preload(10'd3, 32'h33333333);
    obi_rready = 1'b0;
    do_req(32'h1000_0004, 1'b0, 4'hF, '0, 4'd9,  6'h0, 1'b0, 32'h11111111, 1'b0);
    do_req(32'h1000_0008, 1'b0, 4'hF, '0, 4'd10, 6'h0, 1'b0, 32'h22222222, 1'b0);
    set_req(32'h1000_000C, 1'b0, 4'hF, '0, 4'd11, 6'h0, 1'b0, 32'h33333333, 1'b0);
    repeat (4) begin
      @(negedge clk);
      chk("bp_gnt_low", {31'd0, obi_gnt}, 32'd0);
      chk("bp_rvalid_held", {31'd0, obi_rvalid}, 32'd1);
    end
    @(posedge clk); #1;
    obi_rready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!obi_gnt && n < 20) begin n++; @(negedge clk); end
    chk("bp_third_gnt", {31'd0, obi_gnt}, 32'd1);
    @(posedge clk); #1;
    obi_req = 1'b0;
    idle(4);
    chk("bp_all_drained", exp_q.size(), 32'd0);

    // Streaming: 16 back-to-back reads with no stall
    for (int i = 0; i < 16; i++) preload(10'(16 + i), 32'hA500_0000 + 32'(i));
    stalls = 0;
    for (int i = 0; i < 16; i++)
      do_req(BASE + 32'((16 + i) * 4), 1'b0, 4'hF, '0, 4'(i), 6'h0, 1'b0,
             32'hA500_0000 + 32'(i), 1'b1);
    chk("stream_no_stall", stalls, 32'd0);
    idle(3);
    chk("stream_drained", exp_q.size(), 32'd0);

    // Reset with two responses pending
    obi_rready = 1'b0;
    do_req(32'h1000_0004, 1'b0, 4'hF, '0, 4'd12, 6'h0, 1'b0, 32'h11111111, 1'b0);
    do_req(32'h1000_0008, 1'b0, 4'hF, '0, 4'd13, 6'h0, 1'b0, 32'h22222222, 1'b0);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("midreset_rvalid", {31'd0, obi_rvalid}, 32'd0);
    chk("midreset_gnt", {31'd0, obi_gnt}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; obi_rready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("no_stale_rvalid", {31'd0, obi_rvalid}, 32'd0);
    end
    @(posedge clk); #1;
    do_req(32'h1000_0014, 1'b0, 4'hF, '0, 4'd14, 6'h0, 1'b0, 32'hDEADBEEF, 1'b1);
    idle(3);
    chk("final_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/obi_sram_responder.md
# obi_sram_responder

OBI subordinate that serves core data-port requests from one single-port, 1-cycle-latency SRAM macro inside the tile. It sits behind the OBI crossbar as the slave for one address rule. It grants requests, drives the SRAM, and returns in-order R-channel responses with the request's `aid` echoed as `rid`. Up to `MAX_OUTSTANDING` responses may be held back by `rready`. Out-of-range and atomic requests get an error response and never touch the SRAM.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h1000_0000: first byte address served.
- `N_WORDS`, default 1024: SRAM depth in 32-bit words. Must be a power of two.
- `MAX_OUTSTANDING`, default 2: maximum number of granted responses not yet accepted. Must be ≥1.
- `USE_RREADY`, default 0: if 0, `obi_rready_i` is ignored and treated as 1.

Ports:
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: asynchronous, active-high reset.
- `obi_req_i`, in, 1: A-channel request.
- `obi_gnt_o`, out, 1: A-channel grant.
- `obi_addr_i`, in, 32: byte address.
- `obi_we_i`, in, 1: 1 = write.
- `obi_be_i`, in, 4: byte enables.
- `obi_wdata_i`, in, 32: write data.
- `obi_aid_i`, in, `AID_WIDTH`: transaction id.
- `obi_atop_i`, in, 6: atomic opcode.
- `obi_rvalid_o`, out, 1: response valid.
- `obi_rready_i`, in, 1: response ready.
- `obi_rdata_o`, out, 32: read data.
- `obi_rid_o`, out, `RID_WIDTH`: echoed `aid`.
- `obi_err_o`, out, 1: error flag.
- `sram_req_o`, out, 1: SRAM access.
- `sram_we_o`, out, 1: SRAM write enable.
- `sram_addr_o`, out, log2(`N_WORDS`): SRAM word address.
- `sram_be_o`, out, 4: SRAM byte enables.
- `sram_wdata_o`, out, 32: SRAM write data.
- `sram_rdata_i`, in, 32: SRAM read data, valid one cycle after the access.

## Operation
- Handshake: a request is accepted on any cycle where `obi_req_i & obi_gnt_o`. A/R ordering follows OBI. Responses are returned strictly in acceptance order.
- Grant: `obi_gnt_o = (outstanding_q < MAX_OUTSTANDING)`.
  - Grant is registered-state-only and does not depend on `obi_req_i` or `obi_rready_i`.
  - It may be high without a request.
- Outstanding counter:
  - +1 on acceptance.
  - −1 on `obi_rvalid_o & rready_eff`.
  - Unchanged when both happen in the same cycle.
  - Width is log2(`MAX_OUTSTANDING`+1).
- Decode: `hit = (addr − BASE_ADDR) < N_WORDS*4`, computed as unsigned 32-bit.
  - A request is bad when `!hit | (atop != 0)`.
- Good accepted request:
  - Drive the SRAM in the same cycle: `sram_req_o=1`, word address `(addr−BASE_ADDR)>>2`, and pass `we`/`be`/`wdata` through.
  - The response has `err=0`.
  - `rdata` is `sram_rdata_i` for reads and 0 for writes.
- Bad accepted request: `sram_req_o=0`, `err=1`, `rdata=0`.
- Response pipeline:
  - Stage 1 register holds {valid, rid, err, is_read} of the request accepted in the previous cycle.
  - Its payload, with `rdata` taken from the SRAM, is pushed into the response FIFO (depth `MAX_OUTSTANDING`, fall-through).
  - The R channel is driven from the FIFO head, so an empty FIFO presents the pushed entry in the same cycle.
  - Because of the grant rule, the FIFO never overflows. The bench must assert no push when full.
- Unaligned addresses: low two address bits are ignored and `be` is used as given. This is not an error.

## Timing
- Reset values: `obi_gnt_o=1` (after reset, outstanding=0); all other outputs are 0. Counter, stage 1 and FIFO are cleared.
- Latency: a request accepted in cycle T has `obi_rvalid_o=1` in cycle T+1 when the FIFO is empty. Bad requests use the same latency.
- Throughput: one transaction per cycle sustained while `rready_eff=1` and `MAX_OUTSTANDING≥2`. With `MAX_OUTSTANDING=1`, the rate is one transaction every 2 cycles.
- Back-pressure: while `rready_eff=0`, responses stay on the R channel with stable values. Grant falls once the counter reaches `MAX_OUTSTANDING`.
- Simultaneous accept and release at a full count: the counter is unchanged and grant stays low that cycle; the decision uses the registered count.
- Reset mid-operation: in-flight responses are dropped. SRAM writes already issued are not undone.

## Structure
- Add to the tile package (`redmule_tile_pkg`):
  - a `rsp_entry_t` struct {rid, err, rdata};
  - the constant `L1_SRAM_WORDS`.
- The A/R channel fields reuse the existing OBI typedefs of the package.
- One sub-module: `obi_rsp_fifo`, a parameterised fall-through FIFO with depth and entry type, and full/empty outputs.

## Test plan
- Single read: preload word 5 with 32'hDEADBEEF; read at 32'h1000_0014 with aid=1. Expect rvalid at T+1 with rdata=32'hDEADBEEF, rid=1, err=0.
- Byte write: with `be=4'b0010` and wdata=32'h0000AB00 to 32'h1000_0000 (word initially 0), then read it back. Expect 32'h0000AB00, err=0 both times, and SRAM written exactly once.
- Errors: read at 32'h1000_1000 (N_WORDS=1024), and a write with atop=6'h21. Expect err=1 and rdata=0 for both, and `sram_req_o` never asserted.
- Back-pressure (`USE_RREADY=1`, `MAX_OUTSTANDING=2`): hold rready=0 while issuing 3 back-to-back reads. Expect gnt to drop after 2 accepts. Release rready and expect 2 responses in order, then the third accepted.
- Streaming: 16 consecutive reads with rready=1. Expect 16 accepts in 16 cycles and responses in T+1..T+16 in order.
- Reset: assert `rst_i` with 2 responses pending. Expect rvalid=0 and gnt=1 in the following cycle, and no stale response afterwards.
